// File: rtl/reduction_int_seq_ctrl_if.sv
// Stream-in / result-out bundle for the adder-tree sequencer.
// The slave side is the sequencer; the master side is the environment feeding it.
interface reduction_int_seq_ctrl_if #(
  parameter int unsigned PHIT = 512,
  parameter int unsigned DW   = 64
) ();
  logic [PHIT-1:0] s_tdata;
  logic            s_tvalid;
  logic            s_tready;
  logic [DW-1:0]   m_data;
  logic            m_valid;
  logic            m_ready;

  modport slave (
    input  s_tdata, s_tvalid, m_ready,
    output s_tready, m_data, m_valid
  );

  modport master (
    output s_tdata, s_tvalid, m_ready,
    input  s_tready, m_data, m_valid
  );
endinterface

// File: rtl/reduction_int_seq_ctrl.sv
// Feeds a cfg_len-phit message into an external registered adder tree and
// accumulates the tree outputs into one scalar returned on a valid/ready port.
module reduction_int_seq_ctrl #(
  parameter int unsigned phit_size     = 512,
  parameter int unsigned dwidth_double = 64,
  parameter int unsigned LANES         = 8,
  parameter int unsigned TREE_LAT      = 3,
  parameter int unsigned LEN_W         = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [LEN_W-1:0]         cfg_len,
  output logic                     busy,
  reduction_int_seq_ctrl_if.slave  bus,
  output logic [phit_size-1:0]     tree_inp,
  input  logic [dwidth_double-1:0] tree_out
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FEED   = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;
  localparam logic [1:0] S_RESULT = 2'd3;

  logic [1:0]                     state_q, state_d;
  logic [LEN_W-1:0]               count_q, count_d;
  logic [LEN_W-1:0]               len_q, len_d;
  logic [dwidth_double-1:0]       acc_q, acc_d;
  logic [TREE_LAT-1:0]            vpipe_q, vpipe_d;
  logic [TREE_LAT-1:0]            vpipe_shl;
  logic [LANES*dwidth_double-1:0] feed;
  logic                           hs;
  logic                           last_beat;
  logic                           drain_done;

  assign bus.s_tready = (state_q == S_FEED);
  assign bus.m_valid  = (state_q == S_RESULT);
  assign bus.m_data   = bus.m_valid ? acc_q : '0;
  assign busy         = (state_q != S_IDLE);

  assign hs        = bus.s_tvalid & bus.s_tready;
  assign last_beat = (count_q == len_q - 1'b1);

  // Idle cycles push zeros so a bubble in the tree adds nothing to acc.
  assign feed     = hs ? bus.s_tdata : '0;
  assign tree_inp = feed;

  // The top bit is the beat the tree presents this cycle; once every bit
  // below it is clear, the accumulation happening now is the last one.
  assign vpipe_shl  = vpipe_q << 1;
  assign vpipe_d    = vpipe_shl | TREE_LAT'(hs);
  assign drain_done = (vpipe_shl == '0);

  always_comb begin
    // NOTE: every next-state signal gets a default here so no branch can
    // leave one unassigned and infer a latch.
    state_d = state_q;
    count_d = count_q;
    len_d   = len_q;
    acc_d   = vpipe_q[TREE_LAT-1] ? acc_q + tree_out : acc_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d   = cfg_len;
          count_d = '0;
          acc_d   = '0;
          state_d = (cfg_len == '0) ? S_RESULT : S_FEED;
        end
      end
      S_FEED: begin
        if (hs) begin
          count_d = count_q + 1'b1;
          if (last_beat) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (drain_done) state_d = S_RESULT;
      end
      S_RESULT: begin
        if (bus.m_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      len_q   <= '0;
      acc_q   <= '0;
      vpipe_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      len_q   <= len_d;
      acc_q   <= acc_d;
      vpipe_q <= vpipe_d;
    end
  end

endmodule

// File: tb/tb_reduction_int_seq_ctrl.sv
// Self-checking bench for reduction_int_seq_ctrl with a behavioural adder tree.
module tb_reduction_int_seq_ctrl;

  localparam int unsigned PHIT     = 512;
  localparam int unsigned DW       = 64;
  localparam int unsigned LANES    = 8;
  localparam int unsigned TREE_LAT = 3;
  localparam int unsigned LEN_W    = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [LEN_W-1:0] cfg_len;
  logic             busy;
  logic [PHIT-1:0]  tree_inp;
  logic [DW-1:0]    tree_out;

  always #5 clk = ~clk;

  reduction_int_seq_ctrl_if #(.PHIT(PHIT), .DW(DW)) bus ();

  reduction_int_seq_ctrl #(
    .phit_size(PHIT), .dwidth_double(DW), .LANES(LANES),
    .TREE_LAT(TREE_LAT), .LEN_W(LEN_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len), .busy(busy),
    .bus(bus), .tree_inp(tree_inp), .tree_out(tree_out)
  );

  // Behavioural tree: wrapping lane sum, delayed TREE_LAT registers.
  logic [DW-1:0] t_sum;
  logic [DW-1:0] t_q [TREE_LAT];
  always_comb begin
    t_sum = '0;
    for (int l = 0; l < LANES; l++) t_sum = t_sum + tree_inp[l*DW +: DW];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TREE_LAT; i++) t_q[i] <= '0;
    end else begin
      t_q[0] <= t_sum;
      for (int i = 1; i < TREE_LAT; i++) t_q[i] <= t_q[i-1];
    end
  end
  assign tree_out = t_q[TREE_LAT-1];

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor / scoreboard
  logic [DW-1:0] sb_q [$];
  int unsigned   cyc = 0;
  int unsigned   hs_cnt = 0;
  int unsigned   last_hs_cyc = 0;
  int unsigned   result_cyc = 0;
  int unsigned   results_seen = 0;
  bit            saw_tready = 1'b0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (rst !== 1'b1) begin
      if (bus.s_tvalid && bus.s_tready) begin
        hs_cnt++;
        last_hs_cyc = cyc;
      end
      if (bus.s_tready) saw_tready = 1'b1;
      if (bus.m_valid && bus.m_ready) begin
        check("sb_has_entry", 64'(sb_q.size() != 0), 64'd1);
        if (sb_q.size() != 0) check("m_data", bus.m_data, sb_q.pop_front());
        results_seen++;
        result_cyc = cyc;
      end
    end
  end

  typedef struct {
    string       name;
    int unsigned len;
    logic [63:0] base;
    logic [63:0] step;
    bit          gaps;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs [7];

  function automatic logic [PHIT-1:0] make_phit(input logic [63:0] base, input logic [63:0] step);
    logic [PHIT-1:0] p;
    for (int l = 0; l < LANES; l++) p[l*DW +: DW] = base + step * 64'(l);
    return p;
  endfunction

  task automatic pulse_start(input int unsigned len, output int unsigned start_cyc);
    @(posedge clk); #1;
    start   = 1'b1;
    cfg_len = LEN_W'(len);
    @(negedge clk);
    start_cyc = cyc;
    @(posedge clk); #1;
    start   = 1'b0;
    cfg_len = '0;
  endtask

  task automatic run_msg(input vec_t v);
    int unsigned beats;
    int unsigned guard;
    int unsigned start_cyc;
    int unsigned prev_res;
    bit          phase;
    sb_q.push_back(v.exp);
    hs_cnt      = 0;
    saw_tready  = 1'b0;
    prev_res    = results_seen;
    bus.m_ready = 1'b1;
    pulse_start(v.len, start_cyc);
    beats = 0;
    guard = 0;
    phase = 1'b1;
    while (beats < v.len && guard < 200) begin
      bus.s_tvalid = v.gaps ? phase : 1'b1;
      bus.s_tdata  = make_phit(v.base, v.step);
      @(negedge clk);
      if (bus.s_tvalid && bus.s_tready) beats++;
      @(posedge clk); #1;
      phase = ~phase;
      guard++;
    end
    bus.s_tvalid = 1'b0;
    bus.s_tdata  = '0;
    if (v.len != 0) begin
      if (!v.gaps) check({v.name, "_throughput"}, 64'(guard), 64'(v.len));
      @(negedge clk);
      check({v.name, "_tready_low_after_last"}, 64'(bus.s_tready), 64'd0);
    end
    guard = 0;
    while (results_seen == prev_res && guard < 30) begin
      @(posedge clk);
      guard++;
    end
    check({v.name, "_result_seen"}, 64'(results_seen), 64'(prev_res + 1));
    check({v.name, "_beats"}, 64'(hs_cnt), 64'(v.len));
    if (v.len == 0) begin
      check({v.name, "_tready_never"}, 64'(saw_tready), 64'd0);
      check({v.name, "_latency"}, 64'(result_cyc - start_cyc), 64'd1);
    end else begin
      check({v.name, "_latency"}, 64'(result_cyc - last_hs_cyc), 64'(TREE_LAT + 1));
    end
    @(negedge clk);
    check({v.name, "_mvalid_one_cycle"}, 64'(bus.m_valid), 64'd0);
    check({v.name, "_idle_after"}, 64'(busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned sc;
    int unsigned guard;
    vec_t        v;

    vecs[0] = '{"lanes_1_to_8", 1,  64'd1,  64'd1,  1'b0, 64'd36};
    vecs[1] = '{"gapped_4",     4,  64'd1,  64'd0,  1'b1, 64'd32};
    vecs[2] = '{"wrap_ones",    1,  64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8};
    vecs[3] = '{"len_zero",     0,  64'd7,  64'd1,  1'b0, 64'd0};
    vecs[4] = '{"ramp_3",       3,  64'd10, 64'd10, 1'b0, 64'd1080};
    vecs[5] = '{"msb_wrap_2",   2,  64'h8000_0000_0000_0001, 64'd0, 1'b1, 64'd16};
    vecs[6] = '{"long_20",      20, 64'd1,  64'd2,  1'b0, 64'd1280};

    rst          = 1'b1;
    start        = 1'b0;
    cfg_len      = '0;
    bus.s_tvalid = 1'b0;
    bus.s_tdata  = '0;
    bus.m_ready  = 1'b0;
    bus.s_tdata  = make_phit(64'd9, 64'd1);
    bus.s_tvalid = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy",     64'(busy),         64'd0);
    check("rst_tready",   64'(bus.s_tready), 64'd0);
    check("rst_mvalid",   64'(bus.m_valid),  64'd0);
    check("rst_mdata",    bus.m_data,        64'd0);
    check("rst_tree_inp", 64'(tree_inp != '0), 64'd0);
    bus.s_tvalid = 1'b0;
    bus.s_tdata  = '0;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_idle", 64'(busy), 64'd0);

    for (int i = 0; i < 7; i++) run_msg(vecs[i]);

    // Result stall: m_ready low for 10 cycles with a stray start pulse.
    sb_q.push_back(64'd40);
    bus.m_ready = 1'b0;
    pulse_start(1, sc);
    bus.s_tvalid = 1'b1;
    bus.s_tdata  = make_phit(64'd5, 64'd0);
    @(posedge clk); #1;
    bus.s_tvalid = 1'b0;
    bus.s_tdata  = '0;
    guard = 0;
    while (bus.m_valid !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("stall_reached_result", 64'(bus.m_valid), 64'd1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      start   = (i == 4);
      cfg_len = (i == 4) ? LEN_W'(7) : '0;
      @(negedge clk);
      check("stall_mvalid", 64'(bus.m_valid), 64'd1);
      check("stall_mdata",  bus.m_data,       64'd40);
    end
    @(posedge clk); #1;
    start       = 1'b0;
    cfg_len     = '0;
    bus.m_ready = 1'b1;
    @(negedge clk);
    check("stall_release_valid", 64'(bus.m_valid), 64'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stray_start_ignored_busy",   64'(busy),         64'd0);
      check("stray_start_ignored_tready", 64'(bus.s_tready), 64'd0);
    end

    // Reset in the middle of a 5-beat message.
    pulse_start(5, sc);
    hs_cnt       = 0;
    bus.s_tvalid = 1'b1;
    bus.s_tdata  = make_phit(64'd3, 64'd0);
    guard = 0;
    while (hs_cnt < 2 && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    check("abort_two_beats", 64'(hs_cnt), 64'd2);
    rst = 1'b1;
    #1;
    check("abort_busy",     64'(busy),          64'd0);
    check("abort_tready",   64'(bus.s_tready),  64'd0);
    check("abort_mvalid",   64'(bus.m_valid),   64'd0);
    check("abort_mdata",    bus.m_data,         64'd0);
    check("abort_tree_inp", 64'(tree_inp != '0), 64'd0);
    bus.s_tvalid = 1'b0;
    bus.s_tdata  = '0;
    @(negedge clk);
    rst = 1'b0;
    v = '{"after_abort", 1, 64'd2, 64'd0, 1'b0, 64'd16};
    run_msg(v);

    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
